// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the M1 write-channel route controller.
// Bus widths default to 32-bit address / 8-bit burst length unless predefined.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

package axi_wr_pkg;

    localparam int ADDR_W = `AXI_ADDR_BITS;
    localparam int LEN_W  = `AXI_LEN_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } wr_state_t;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_M1_S0 = 2'd1;
    localparam logic [1:0] W_M1_S1 = 2'd2;
    localparam logic [1:0] W_DEF   = 2'd3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [15:0] S0_BASE = 16'h0000;
    localparam logic [15:0] S1_BASE = 16'h0001;

endpackage

// File: rtl/axi_default_slave_w.sv
// Default slave write responder: accepts address and data for unmapped
// targets and answers DECERR; only built when AXI_WR_DECERR_EN is defined.
module axi_default_slave_w
    import axi_wr_pkg::*;
(
    input  wr_state_t  state,
    input  logic [1:0] tgt,
    output logic       DS_AWREADY,
    output logic       DS_WREADY,
    output logic       DS_BVALID,
    output logic [1:0] DS_BRESP
);

    logic sel;

    assign sel        = (tgt == W_DEF);
    assign DS_AWREADY = sel && (state == ST_ADDR);
    assign DS_WREADY  = sel && (state == ST_DATA);
    assign DS_BVALID  = sel && (state == ST_RESP);
    assign DS_BRESP   = DS_BVALID ? DECERR : OKAY;

endmodule

// File: rtl/axi_write_ctrl.sv
// Single-outstanding M1 write route controller driving the AW/W/B mux select.
// Define AXI_WR_DECERR_EN to route unmapped addresses to the default slave.
module axi_write_ctrl
    import axi_wr_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [LEN_W-1:0]  AWLEN_M1,
    input  logic              AWVALID_M1,
    input  logic              AWREADY_M1,
    input  logic              WVALID_M1,
    input  logic              WREADY_M1,
    input  logic              WLAST_M1,
    input  logic              BVALID_M1,
    input  logic              BREADY_M1,
    output logic [1:0]        W_state,
    output logic              len_err,
    output logic              DS_AWREADY,
    output logic              DS_WREADY,
    output logic              DS_BVALID,
    output logic [1:0]        DS_BRESP
);

    wr_state_t        state_q, state_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]       decoded_tgt;
    logic             beat;
    logic             unused_addr;

    assign unused_addr = ^AWADDR_M1;
    assign beat        = WVALID_M1 && WREADY_M1;

    always_comb begin
        decoded_tgt = W_M1_S0;
`ifdef AXI_WR_DECERR_EN
        if (AWADDR_M1[31:16] == S0_BASE)
            decoded_tgt = W_M1_S0;
        else if (AWADDR_M1[31:16] == S1_BASE)
            decoded_tgt = W_M1_S1;
        else
            decoded_tgt = W_DEF;
`else
        decoded_tgt = AWADDR_M1[16] ? W_M1_S1 : W_M1_S0;
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            tgt_q      <= W_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // len_err flags a WLAST that disagrees with the latched length; the burst
    // still terminates only on WLAST so the downstream slave stays in sync.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        len_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID_M1) begin
                    tgt_d   = decoded_tgt;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (AWVALID_M1 && AWREADY_M1) begin
                    len_d      = AWLEN_M1;
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    len_err    = WLAST_M1 ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q);
                    if (WLAST_M1)
                        state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (BVALID_M1 && BREADY_M1)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign W_state = (state_q == ST_IDLE) ? W_IDLE : tgt_q;

`ifdef AXI_WR_DECERR_EN
    axi_default_slave_w u_default_slave (
        .state      (state_q),
        .tgt        (tgt_q),
        .DS_AWREADY (DS_AWREADY),
        .DS_WREADY  (DS_WREADY),
        .DS_BVALID  (DS_BVALID),
        .DS_BRESP   (DS_BRESP)
    );
`else
    assign DS_AWREADY = 1'b0;
    assign DS_WREADY  = 1'b0;
    assign DS_BVALID  = 1'b0;
    assign DS_BRESP   = OKAY;
`endif

endmodule

// File: tb/tb_axi_write_ctrl.sv
// Self-checking bench for axi_write_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_axi_write_ctrl;

    typedef struct {
        logic        rst;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic        awvalid;
        logic        awready;
        logic        wvalid;
        logic        wready;
        logic        wlast;
        logic        bvalid;
        logic        bready;
    } stim_t;

    localparam int P_IDLE = 0;
    localparam int P_ADDR = 1;
    localparam int P_DATA = 2;
    localparam int P_RESP = 3;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR_M1;
    logic [7:0]  AWLEN_M1;
    logic        AWVALID_M1, AWREADY_M1;
    logic        WVALID_M1, WREADY_M1, WLAST_M1;
    logic        BVALID_M1, BREADY_M1;
    logic [1:0]  W_state;
    logic        len_err;
    logic        DS_AWREADY, DS_WREADY, DS_BVALID;
    logic [1:0]  DS_BRESP;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Transaction-level reference: where the single outstanding write is.
    int m_phase = P_IDLE;
    int m_tgt   = 0;
    int m_len   = 0;
    int m_beats = 0;

    logic [1:0] s_ws;
    logic       s_err;

    axi_write_ctrl dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .AWADDR_M1  (AWADDR_M1),
        .AWLEN_M1   (AWLEN_M1),
        .AWVALID_M1 (AWVALID_M1),
        .AWREADY_M1 (AWREADY_M1),
        .WVALID_M1  (WVALID_M1),
        .WREADY_M1  (WREADY_M1),
        .WLAST_M1   (WLAST_M1),
        .BVALID_M1  (BVALID_M1),
        .BREADY_M1  (BREADY_M1),
        .W_state    (W_state),
        .len_err    (len_err),
        .DS_AWREADY (DS_AWREADY),
        .DS_WREADY  (DS_WREADY),
        .DS_BVALID  (DS_BVALID),
        .DS_BRESP   (DS_BRESP)
    );

    always #5 ACLK = ~ACLK;

    function automatic int decode(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 1;
        if (a[31:16] == 16'h0001) return 2;
`ifdef AXI_WR_DECERR_EN
        return 3;
`else
        return a[16] ? 2 : 1;
`endif
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0; s.awaddr = '0; s.awlen = '0; s.awvalid = 1'b0; s.awready = 1'b0;
        s.wvalid = 1'b0; s.wready = 1'b0; s.wlast = 1'b0; s.bvalid = 1'b0; s.bready = 1'b0;
        return s;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int  e_ws, e_err, e_aw, e_w, e_b, e_resp;
        bit  hs;
        e_ws  = (m_phase == P_IDLE) ? 0 : m_tgt;
        hs    = WVALID_M1 && WREADY_M1;
        e_err = (m_phase == P_DATA && hs &&
                 (WLAST_M1 ? ((m_beats % 256) != m_len) : ((m_beats % 256) == m_len))) ? 1 : 0;
`ifdef AXI_WR_DECERR_EN
        e_aw   = (m_phase == P_ADDR && m_tgt == 3) ? 1 : 0;
        e_w    = (m_phase == P_DATA && m_tgt == 3) ? 1 : 0;
        e_b    = (m_phase == P_RESP && m_tgt == 3) ? 1 : 0;
        e_resp = e_b ? 3 : 0;
`else
        e_aw = 0; e_w = 0; e_b = 0; e_resp = 0;
`endif
        compare("W_state", 32'(W_state), 32'(e_ws));
        compare("len_err", 32'(len_err), 32'(e_err));
        compare("DS_AWREADY", 32'(DS_AWREADY), 32'(e_aw));
        compare("DS_WREADY", 32'(DS_WREADY), 32'(e_w));
        compare("DS_BVALID", 32'(DS_BVALID), 32'(e_b));
        compare("DS_BRESP", 32'(DS_BRESP), 32'(e_resp));
    endtask

    task automatic modelUpdate();
        if (ARESET) begin
            m_phase = P_IDLE; m_tgt = 0; m_len = 0; m_beats = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (AWVALID_M1) begin m_tgt = decode(AWADDR_M1); m_phase = P_ADDR; end
                P_ADDR: if (AWVALID_M1 && AWREADY_M1) begin
                            m_len = int'(AWLEN_M1); m_beats = 0; m_phase = P_DATA;
                        end
                P_DATA: if (WVALID_M1 && WREADY_M1) begin
                            m_beats++;
                            if (WLAST_M1) m_phase = P_RESP;
                        end
                default: if (BVALID_M1 && BREADY_M1) m_phase = P_IDLE;
            endcase
        end
    endtask

    // Called just after a rising edge; drives one cycle, checks mid-cycle.
    task automatic applyStimulus(input stim_t s);
        ARESET = s.rst; AWADDR_M1 = s.awaddr; AWLEN_M1 = s.awlen;
        AWVALID_M1 = s.awvalid; AWREADY_M1 = s.awready;
        WVALID_M1 = s.wvalid; WREADY_M1 = s.wready; WLAST_M1 = s.wlast;
        BVALID_M1 = s.bvalid; BREADY_M1 = s.bready;
        @(negedge ACLK);
        s_ws  = W_state;
        s_err = len_err;
        if (chk_en) checkOutput();
        modelUpdate();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pin(input string name, input int exp_ws, input int exp_err);
        compare({name, ".W_state"}, 32'(s_ws), 32'(exp_ws));
        compare({name, ".len_err"}, 32'(s_err), 32'(exp_err));
    endtask

    task automatic cycIdle();
        applyStimulus(idle_stim());
    endtask

    task automatic cycAw(input logic [31:0] addr, input logic [7:0] len, input logic rdy);
        stim_t s;
        s = idle_stim(); s.awvalid = 1'b1; s.awaddr = addr; s.awlen = len; s.awready = rdy;
        applyStimulus(s);
    endtask

    task automatic cycBeat(input logic last);
        stim_t s;
        s = idle_stim(); s.wvalid = 1'b1; s.wready = 1'b1; s.wlast = last;
        applyStimulus(s);
    endtask

    task automatic cycB(input logic rdy);
        stim_t s;
        s = idle_stim(); s.bvalid = 1'b1; s.bready = rdy;
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;
        int    exp_unmapped;
`ifdef AXI_WR_DECERR_EN
        exp_unmapped = 3;
`else
        exp_unmapped = 1;
`endif
        ARESET = 1'b1; AWADDR_M1 = '0; AWLEN_M1 = '0; AWVALID_M1 = 1'b0; AWREADY_M1 = 1'b0;
        WVALID_M1 = 1'b0; WREADY_M1 = 1'b0; WLAST_M1 = 1'b0; BVALID_M1 = 1'b0; BREADY_M1 = 1'b0;
        @(posedge ACLK);
        #1;
        s = idle_stim(); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        chk_en = 1'b1;

        $display("[TB] reset state");
        cycIdle();                       pin("reset", 0, 0);

        $display("[TB] four-beat burst to S0");
        cycAw(32'h0000_0010, 8'd3, 1'b0); pin("s0.aw_idle", 0, 0);
        cycAw(32'h0000_0010, 8'd3, 1'b1); pin("s0.addr", 1, 0);
        cycBeat(1'b0);                   pin("s0.b1", 1, 0);
        cycBeat(1'b0);                   pin("s0.b2", 1, 0);
        cycBeat(1'b0);                   pin("s0.b3", 1, 0);
        cycBeat(1'b1);                   pin("s0.b4", 1, 0);
        cycB(1'b1);                      pin("s0.resp", 1, 0);
        cycIdle();                       pin("s0.done", 0, 0);

        $display("[TB] single beat to S1");
        cycAw(32'h0001_0000, 8'd0, 1'b0); pin("s1.aw_idle", 0, 0);
        cycAw(32'h0001_0000, 8'd0, 1'b1); pin("s1.addr", 2, 0);
        cycBeat(1'b1);                   pin("s1.last", 2, 0);
        cycB(1'b0);                      pin("s1.resp_wait", 2, 0);
        cycB(1'b1);                      pin("s1.resp", 2, 0);
        cycIdle();                       pin("s1.done", 0, 0);

        $display("[TB] early WLAST");
        cycAw(32'h0000_0200, 8'd3, 1'b1);
        cycAw(32'h0000_0200, 8'd3, 1'b1);
        cycBeat(1'b0);                   pin("early.b1", 1, 0);
        cycBeat(1'b1);                   pin("early.b2", 1, 1);
        cycB(1'b1);                      pin("early.resp", 1, 0);
        cycIdle();

        $display("[TB] unmapped address");
        cycAw(32'h2000_0000, 8'd1, 1'b0);
        cycAw(32'h2000_0000, 8'd1, 1'b1); pin("unm.addr", exp_unmapped, 0);
`ifdef AXI_WR_DECERR_EN
        compare("unm.DS_AWREADY", 32'(DS_AWREADY), 32'd0);
`endif
        cycBeat(1'b0);
        cycBeat(1'b1);                   pin("unm.last", exp_unmapped, 0);
        cycB(1'b1);                      pin("unm.resp", exp_unmapped, 0);
        cycIdle();

        $display("[TB] reset mid-burst");
        cycAw(32'h0000_0300, 8'd5, 1'b1);
        cycAw(32'h0000_0300, 8'd5, 1'b1);
        cycBeat(1'b0);
        cycBeat(1'b0);
        s = idle_stim(); s.rst = 1'b1; s.wvalid = 1'b1; s.wready = 1'b1;
        applyStimulus(s);                pin("rst.cycle", 1, 0);
        cycIdle();                       pin("rst.after", 0, 0);
        cycAw(32'h0001_0040, 8'd1, 1'b1);
        cycAw(32'h0001_0040, 8'd1, 1'b1); pin("rst.new_addr", 2, 0);
        cycBeat(1'b0);
        cycBeat(1'b1);                   pin("rst.new_last", 2, 0);
        cycB(1'b1);
        cycIdle();                       pin("rst.new_done", 0, 0);

        $display("[TB] AWVALID held during response");
        cycAw(32'h0000_0100, 8'd0, 1'b1);
        cycAw(32'h0000_0100, 8'd0, 1'b1);
        cycBeat(1'b1);
        for (int i = 0; i < 5; i++) begin
            s = idle_stim(); s.awvalid = 1'b1; s.awaddr = 32'h0001_0000; s.awready = 1'b1;
            s.bvalid = 1'b1;
            applyStimulus(s);            pin("hold.resp", 1, 0);
        end
        s = idle_stim(); s.awvalid = 1'b1; s.awaddr = 32'h0001_0000; s.bvalid = 1'b1; s.bready = 1'b1;
        applyStimulus(s);                pin("hold.bhs", 1, 0);
        cycAw(32'h0001_0000, 8'd0, 1'b0); pin("hold.idle", 0, 0);
        cycAw(32'h0001_0000, 8'd0, 1'b1); pin("hold.new", 2, 0);
        cycBeat(1'b1);
        cycB(1'b1);
        cycIdle();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            s = idle_stim();
            s.rst     = ($urandom_range(0, 299) == 0);
            s.awvalid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0:       s.awaddr = {16'h0000, 16'($urandom)};
                1:       s.awaddr = {16'h0001, 16'($urandom)};
                default: s.awaddr = $urandom;
            endcase
            s.awlen   = 8'($urandom_range(0, 3));
            s.awready = 1'($urandom_range(0, 1));
            s.wvalid  = ($urandom_range(0, 3) != 0);
            s.wready  = ($urandom_range(0, 3) != 0);
            s.wlast   = ($urandom_range(0, 5) == 0) ||
                        (m_phase == P_DATA && (m_beats % 256) == m_len && $urandom_range(0, 4) != 0);
            s.bvalid  = 1'($urandom_range(0, 1));
            s.bready  = 1'($urandom_range(0, 1));
            applyStimulus(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_write_ctrl.md
AXI_WRITE_CTRL -- requirements
Module: axi_write_ctrl

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: ACLK input 1 (all state on rising edge); ARESET input 1 (synchronous, active-high).
REQ-002 SHALL have ports: AWADDR_M1 in `AXI_ADDR_BITS (M1 write address); AWLEN_M1 in `AXI_LEN_BITS (burst length-1); AWVALID_M1 in 1; AWREADY_M1 in 1 (from address-channel mux, handshake observation).
REQ-003 SHALL have ports: WVALID_M1 in 1; WREADY_M1 in 1; WLAST_M1 in 1; BVALID_M1 in 1; BREADY_M1 in 1 (all M1-side, observation only).
REQ-004 SHALL have ports: W_state out 2 (route select to AW/W/B muxes: 0 IDLE, 1 M1->S0, 2 M1->S1, 3 default slave); len_err out 1 (one-cycle error pulse).
REQ-005 SHALL have default-slave ports: DS_AWREADY out 1; DS_WREADY out 1; DS_BVALID out 1; DS_BRESP out 2.

Function
REQ-006 SHALL run FSM states IDLE, ADDR, DATA, RESP, plus registered 2-bit target tgt.
REQ-007 IDLE: on AWVALID_M1=1, SHALL decode AWADDR_M1, load tgt, go ADDR; W_state changes the following cycle (1-cycle latency).
REQ-008 Decode: AWADDR_M1[31:16]=16'h0000 -> tgt=1 (S0); 16'h0001 -> tgt=2 (S1); any other value -> see REQ-017/018.
REQ-009 W_state SHALL equal 0 in IDLE and tgt in ADDR, DATA, RESP; never changes mid-transaction.
REQ-010 ADDR: on AWVALID_M1&AWREADY_M1, SHALL latch AWLEN_M1 into len_q, clear beat counter, go DATA; AWVALID_M1 deassert before handshake SHALL NOT change state.
REQ-011 DATA: each WVALID_M1&WREADY_M1 increments beat counter (width `AXI_LEN_BITS, wraps); beat with WLAST_M1=1 SHALL go RESP.
REQ-012 len_err SHALL pulse for one cycle on a WLAST beat with counter!=len_q, or a non-WLAST beat with counter==len_q; FSM still ends burst only on WLAST.
REQ-013 RESP: on BVALID_M1&BREADY_M1 SHALL go IDLE; next request accepted the cycle after returning to IDLE (no back-to-back AW in RESP).
REQ-014 AWLEN_M1=0: single beat, DATA->RESP on first beat with WLAST.
REQ-015 Only one outstanding write transaction; AWVALID_M1 outside IDLE/ADDR SHALL be ignored.

Reset
REQ-016 On ARESET=1 at clock edge, from any state including mid-burst: FSM=IDLE, tgt=0, len_q=0, counter=0, W_state=0, len_err=0, DS_AWREADY=0, DS_WREADY=0, DS_BVALID=0, DS_BRESP=2'b00.

Configuration
REQ-017 With AXI_WR_DECERR_EN defined: unmapped address -> tgt=3; default slave asserts DS_AWREADY=1 in ADDR, DS_WREADY=1 in DATA, DS_BVALID=1 with DS_BRESP=2'b11 (DECERR) in RESP until BREADY_M1.
REQ-018 Without AXI_WR_DECERR_EN: decode uses AWADDR_M1[16] only (0 -> S0, 1 -> S1); tgt=3 never produced; DS_* outputs constant 0.

Structure
REQ-019 Shared package axi_wr_pkg SHALL hold FSM state enum, W_state encodings (W_IDLE, W_M1_S0, W_M1_S1, W_DEF), BRESP codes (OKAY, DECERR), region bases 16'h0000/16'h0001.
REQ-020 Default-slave response logic SHALL be sub-module axi_default_slave_w, instantiated only under AXI_WR_DECERR_EN.

Verification
REQ-021 AWADDR=0x0000_0010, AWLEN=3, 4 beats with WLAST on 4th, B handshake -> W_state 0,1 (from cycle after AWVALID) ...1,0; len_err never 1.
REQ-022 AWADDR=0x0001_0000, AWLEN=0, single WLAST beat -> W_state=2 through RESP, IDLE after B handshake.
REQ-023 AWLEN=3, WLAST on beat 2 -> len_err pulses 1 cycle on beat 2, FSM goes RESP.
REQ-024 AXI_WR_DECERR_EN, AWADDR=0x2000_0000, AWLEN=1 -> W_state=3, DS_AWREADY/DS_WREADY accept, DS_BVALID=1 with DS_BRESP=2'b11; without macro same address -> W_state=1.
REQ-025 ARESET=1 in DATA after 2 beats -> next cycle W_state=0, all outputs reset; new AW to S1 then completes normally.
REQ-026 AWVALID held in RESP with BREADY_M1=0 for 5 cycles -> W_state stays, no re-decode; new transaction begins after B handshake.
